// File: rtl/transposed_filter.sv
// transposed_filter: fixed-coefficient 8-tap low-pass FIR, transposed direct form.
// One signed sample in and one full-precision signed result out on every rising edge.
// The output is scaled by 2^15 relative to the input, so the DC gain is exactly 1.0 in Q15.
module transposed_filter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned TAPS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] noisy_signal,
  output logic [OUT_W-1:0]  filtered_signal
);

  // Symmetric linear-phase taps in Q1.15. They sum to 32768 and their alternating sum is 0.
  localparam logic signed [COEF_W-1:0] Coef [TAPS] = '{
    -16'sd437, -16'sd1064, 16'sd2690, 16'sd15195,
    16'sd15195, 16'sd2690, -16'sd1064, -16'sd437
  };

  logic signed [OUT_W-1:0] x_ext;
  logic signed [OUT_W-1:0] prod [TAPS];
  // z_q[i] holds pipeline register z(i+1); z_q[TAPS-2] is the tail register z7.
  logic signed [OUT_W-1:0] z_q  [TAPS-1];

  // Per-tap products of the current sample. Both operands are sign-extended to OUT_W first.
  // The true product always fits in OUT_W bits, so keeping the low OUT_W bits is exact.
  always_comb begin
    x_ext = OUT_W'($signed(noisy_signal));
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod[k] = x_ext * OUT_W'(Coef[k]);
    end
  end

  // Output register and transposed delay line. Reset clears all history asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filtered_signal <= '0;
      for (int unsigned k = 0; k < TAPS - 1; k++) begin
        z_q[k] <= '0;
      end
    end else begin
      filtered_signal <= prod[0] + z_q[0];
      for (int unsigned k = 1; k < TAPS - 1; k++) begin
        z_q[k-1] <= prod[k] + z_q[k];
      end
      z_q[TAPS-2] <= prod[TAPS-1];
    end
  end

endmodule

// File: tb/tb_transposed_filter.sv
// Self-checking bench for transposed_filter. Expected outputs come from a direct-form
// reference sum over a sample history, or from hand-derived constant tables. They are
// queued as each sample is driven and popped when the output is sampled after the edge.
module tb_transposed_filter;

  logic        clk;
  logic        rst;
  logic [15:0] noisy_signal;
  logic [31:0] filtered_signal;

  int errors = 0;
  int checks = 0;

  int     h [8] = '{-437, -1064, 2690, 15195, 15195, 2690, -1064, -437};
  int     hist [8];
  longint exp_q [$];

  transposed_filter dut (
    .clk             (clk),
    .rst             (rst),
    .noisy_signal    (noisy_signal),
    .filtered_signal (filtered_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Compare at full 64-bit precision so any wrap in the 32-bit output is caught.
  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint model();
    longint acc = 0;
    for (int k = 0; k < 8; k++) acc += longint'(h[k]) * longint'(hist[k]);
    return acc;
  endfunction

  task automatic clear_hist();
    for (int k = 0; k < 8; k++) hist[k] = 0;
  endtask

  // Drive one sample, queue its expected output, then sample the DUT 1 ns after the edge.
  task automatic drive(input int x, input bit use_model, input longint expc, input string tag);
    longint obs;
    @(negedge clk);
    noisy_signal = x[15:0];
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    exp_q.push_back(use_model ? model() : expc);
    @(posedge clk);
    #1;
    obs = longint'($signed(filtered_signal));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed=empty-queue required=entry", tag);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  longint imp_tab  [8] = '{-437, -1064, 2690, 15195, 15195, 2690, -1064, -437};
  longint step_tab [8] = '{-437000, -1501000, 1189000, 16384000, 31579000, 34269000,
                           33205000, 32768000};

  initial begin
    int x;
    rst = 1'b0;
    noisy_signal = 16'd12345;
    clear_hist();

    // Reset held with a nonzero input: output stays 0.
    #1;
    check("reset_t0", longint'($signed(filtered_signal)), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", longint'($signed(filtered_signal)), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    noisy_signal = 16'd0;

    // Impulse response followed by settled zeros.
    drive(1, 1'b0, imp_tab[0], "impulse");
    for (int i = 1; i < 8; i++) drive(0, 1'b0, imp_tab[i], "impulse");
    for (int i = 0; i < 3; i++) drive(0, 1'b0, 0, "impulse_tail");

    // Step of 1000 from rest.
    for (int i = 0; i < 8; i++) drive(1000, 1'b0, step_tab[i], "step");
    for (int i = 0; i < 3; i++) drive(1000, 1'b0, 32768000, "step_steady");

    // Extremes, including the transient between them.
    for (int i = 0; i < 8; i++) drive(-32768, 1'b1, 0, "neg_full_transient");
    for (int i = 0; i < 2; i++) drive(-32768, 1'b0, -64'sd1073741824, "neg_full_steady");
    for (int i = 0; i < 8; i++) drive(32767, 1'b1, 0, "pos_full_transient");
    for (int i = 0; i < 2; i++) drive(32767, 1'b0, 64'sd1073709056, "pos_full_steady");

    // Nyquist: alternating input is fully rejected once the history is all alternating.
    for (int i = 0; i < 16; i++) begin
      x = (i % 2 == 0) ? 1000 : -1000;
      if (i < 7) drive(x, 1'b1, 0, "nyquist_fill");
      else       drive(x, 1'b0, 0, "nyquist_zero");
    end

    // Periodic noisy stream, then asynchronous reset between edges.
    for (int i = 0; i < 64; i++) begin
      x = ((i % 16) * 3701) % 4001 - 2000;
      drive(x, 1'b1, 0, "stream");
    end
    #2;
    rst = 1'b0;
    clear_hist();
    #1;
    check("async_reset", longint'($signed(filtered_signal)), 0);
    noisy_signal = 16'd777;
    @(posedge clk);
    #1;
    check("reset_mid_hold", longint'($signed(filtered_signal)), 0);
    @(negedge clk);
    rst = 1'b1;
    noisy_signal = 16'd0;

    // Clean impulse after release: no residue from the earlier stream.
    drive(1, 1'b0, imp_tab[0], "post_reset_impulse");
    for (int i = 1; i < 8; i++) drive(0, 1'b0, imp_tab[i], "post_reset_impulse");
    drive(0, 1'b0, 0, "post_reset_tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/transposed_filter.md
# transposed_filter

Fixed-coefficient 8-tap low-pass FIR filter in transposed direct form. It accepts one signed 16-bit noisy sample per clock and produces one full-precision signed 32-bit filtered sample per clock. It sits in the signal path between the sample source and downstream consumers. It has no handshake: every rising clock edge is a sample instant.

## Interface
- DATA_W, 16, input sample width (signed two's complement)
- COEF_W, 16, coefficient width (signed Q1.15)
- OUT_W, 32, output width (signed, full precision, no rounding or scaling)
- TAPS, 8, number of taps; coefficients are fixed internal constants, not ports
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset; clears all state
- noisy_signal  input  16  signed input sample x[n], sampled every rising edge
- filtered_signal  output  32  signed registered filter output y[n]

## Operation
- Coefficients h0..h7 (Q1.15), symmetric, linear phase: -437, -1064, 2690, 15195, 15195, 2690, -1064, -437.
- Coefficients sum to 32768, so DC gain is exactly 1.0 in Q15; the output is scaled by 2^15 relative to input.
- The Nyquist response is exactly 0: the alternating sum of the coefficients is 0.
- Transposed structure: one 32-bit product p_k = h_k * x per tap and seven 32-bit pipeline registers z1..z7.
- On every rising edge, with x = noisy_signal:
  - filtered_signal <= p0 + z1
  - z_k <= p_k + z_(k+1) for k = 1..6
  - z7 <= p7
- Result: y[n] = sum over k=0..7 of h_k * x[n-k], where x[n] is the sample taken at edge n.
- Products are 16x16 signed to 32-bit signed. Additions are 32-bit signed.
- Worst-case |y| = 32768 * 38772 = 1,270,480,896, which is below 2^31. Overflow cannot occur and no saturation logic is required.
- No valid/enable input; the filter processes a sample on every clock cycle.

## Timing
- Reset: while rst = 0, filtered_signal and z1..z7 are forced to 0 immediately, independent of clk. The input is ignored.
- The first sample is taken at the first rising edge with rst = 1.
- Latency: a sample taken at edge n contributes h0 * x to filtered_signal immediately after edge n. The output register is the only delay stage before h0.
- An impulse at edge n appears as h_k on filtered_signal after edge n+k.
- Impulse response length is 8 outputs. The 9th output after an isolated impulse is 0.
- Reset mid-stream discards all history. After release, the output depends only on samples taken after release; no residue from before reset.
- Input changes between edges have no effect. The output changes only on a rising edge or on reset assertion.

## Test plan
- Reset: hold rst = 0 with noisy_signal = 12345 across several clocks -> filtered_signal = 0 throughout.
- Impulse: after reset release, drive 1 for one edge then 0 -> outputs -437, -1064, 2690, 15195, 15195, 2690, -1064, -437, then 0 steady.
- Step: drive constant 1000 -> outputs -437000, -1501000, 1189000, 16384000, 31579000, 34269000, 33205000, then 32768000 steady.
- Extremes: constant -32768 -> steady -1073741824. Constant 32767 -> steady 1073709056. No wrap at any point in the transient.
- Nyquist: drive +1000, -1000 alternating -> after the 8-sample fill, filtered_signal = 0 every cycle.
- Mid-stream reset: stream a 64-sample periodic noisy sequence, pulse rst low asynchronously between edges -> output 0 immediately. After release, an impulse gives exactly the clean impulse response with no residue.
